// File: rtl/mem_wait_responder_if.sv
// Request/response channel between the CPU memory stage and the wait-state memory responder.
interface mem_wait_responder_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [31:0]           req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [DATA_WIDTH-1:0] resp_rdata;
    logic                  resp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/mem_wait_responder.sv
// Word-addressed data memory with WAIT_CYCLES wait states per access and one outstanding request.
// Optional feature MEM_RESP_ERR_EN: out-of-range addresses return resp_err instead of aliasing.
module mem_wait_responder #(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 32,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_wait_responder_if.slave  bus,
    output logic                 busy
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                state, state_nxt;
    logic [3:0]            cnt;
    logic                  cap_write;
    logic [31:0]           cap_addr;
    logic [DATA_WIDTH-1:0] cap_wdata;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  err_q;
    logic                  access;
    logic                  addr_oob;
    logic [ADDR_WIDTH-1:0] idx;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    assign idx = cap_addr[ADDR_WIDTH-1:0];

`ifdef MEM_RESP_ERR_EN
    assign addr_oob = |cap_addr[31:ADDR_WIDTH];
`else
    // Upper address bits are ignored, so addresses alias modulo depth.
    logic unused_addr_hi;
    assign unused_addr_hi = ^cap_addr[31:ADDR_WIDTH];
    assign addr_oob       = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        access    = 1'b0;
        case (state)
            IDLE: if (bus.req_valid) state_nxt = WAIT;
            WAIT: if (cnt == 4'd0) begin
                state_nxt = RESP;
                access    = 1'b1;
            end
            RESP: if (bus.resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Reset gates req_ready so nothing is accepted while rst is held low.
    assign bus.req_ready  = (state == IDLE) && rst;
    assign bus.resp_valid = (state == RESP);
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;
    assign busy           = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt       <= '0;
            cap_write <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            if (state == IDLE && bus.req_valid) begin
                cap_write <= bus.req_write;
                cap_addr  <= bus.req_addr;
                cap_wdata <= bus.req_wdata;
                cnt       <= WAIT_INIT;
            end else if (state == WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end

            if (access) begin
                if (addr_oob) begin
                    rdata_q <= '0;
                    err_q   <= 1'b1;
                end else if (cap_write) begin
                    rdata_q <= '0;
                    err_q   <= 1'b0;
                end else begin
                    rdata_q <= mem[idx];
                    err_q   <= 1'b0;
                end
            end else if (state == RESP && bus.resp_ready) begin
                err_q <= 1'b0;
            end
        end
    end

    // Storage is not reset; contents survive rst.
    always_ff @(posedge clk) begin
        if (access && cap_write && !addr_oob) mem[idx] <= cap_wdata;
    end
endmodule

// File: tb/tb_mem_wait_responder.sv
// Directed bench: instance A uses 2 wait states, instance B uses none.
module tb_mem_wait_responder;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic busy_a, busy_b;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    mem_wait_responder_if #(.DATA_WIDTH(32)) bus_a ();
    mem_wait_responder_if #(.DATA_WIDTH(32)) bus_b ();

    mem_wait_responder #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .WAIT_CYCLES(2)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a), .busy(busy_a));
    mem_wait_responder #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .WAIT_CYCLES(0)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b), .busy(busy_b));

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic drv(input bit sel, input logic v, input logic w, input logic [31:0] ad,
                       input logic [31:0] wd, input logic rr);
        if (sel) begin
            bus_b.req_valid = v; bus_b.req_write = w; bus_b.req_addr = ad;
            bus_b.req_wdata = wd; bus_b.resp_ready = rr;
        end else begin
            bus_a.req_valid = v; bus_a.req_write = w; bus_a.req_addr = ad;
            bus_a.req_wdata = wd; bus_a.resp_ready = rr;
        end
    endtask

    function automatic logic vld(input bit sel);
        return sel ? bus_b.resp_valid : bus_a.resp_valid;
    endfunction

    // One transaction; with hold set it returns at a negedge with the response still pending.
    task automatic txn(input bit sel, input logic wr, input logic [31:0] ad, input logic [31:0] wd,
                       input bit hold, output logic [31:0] rd, output logic er, output int lat);
        @(negedge clk);
        drv(sel, 1'b1, wr, ad, wd, 1'b0);
        @(posedge clk);
        @(negedge clk);
        drv(sel, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        lat = 0;
        while (!vld(sel) && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        rd = sel ? bus_b.resp_rdata : bus_a.resp_rdata;
        er = sel ? bus_b.resp_err : bus_a.resp_err;
        if (!hold) begin
            drv(sel, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
            @(posedge clk);
            @(negedge clk);
            drv(sel, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        end
    endtask

    initial begin
        logic [31:0] rd, held;
        logic        er;
        int          lat;
        int          acc_cyc [3];
        int          rsp_cyc [3];
        int          n_acc, n_rsp;
        bit          pend;
        logic [31:0] exp_b [3];

        vecs[0] = '{1'b1, 32'h05, 32'hDEADBEEF, 32'h0, 1'b0};
        vecs[1] = '{1'b0, 32'h05, 32'h0, 32'hDEADBEEF, 1'b0};
        vecs[2] = '{1'b1, 32'h00, 32'h11110000, 32'h0, 1'b0};
        vecs[3] = '{1'b1, 32'h07, 32'h00000000, 32'h0, 1'b0};
        vecs[4] = '{1'b1, 32'hFF, 32'hCAFEF00D, 32'h0, 1'b0};
        vecs[5] = '{1'b0, 32'hFF, 32'h0, 32'hCAFEF00D, 1'b0};
        vecs[6] = '{1'b0, 32'h00, 32'h0, 32'h11110000, 1'b0};
`ifdef MEM_RESP_ERR_EN
        vecs[7] = '{1'b1, 32'h100, 32'hAAAA5555, 32'h0, 1'b1};
        vecs[8] = '{1'b0, 32'h000, 32'h0, 32'h11110000, 1'b0};
`else
        vecs[7] = '{1'b1, 32'h105, 32'h0BADF00D, 32'h0, 1'b0};
        vecs[8] = '{1'b0, 32'h005, 32'h0, 32'h0BADF00D, 1'b0};
`endif
        exp_b = '{32'hB0, 32'hB1, 32'hB2};

        drv(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        drv(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        #1;
        chk("rst_resp_valid", 32'(bus_a.resp_valid), 32'h0);
        chk("rst_busy", 32'(busy_a), 32'h0);
        chk("rst_rdata", bus_a.resp_rdata, 32'h0);
        chk("rst_err", 32'(bus_a.resp_err), 32'h0);
        chk("rst_req_ready", 32'(bus_a.req_ready), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_req_ready", 32'(bus_a.req_ready), 32'h1);

        for (int i = 0; i < 9; i++) begin
            txn(1'b0, vecs[i].wr, vecs[i].addr, vecs[i].wdata, 1'b0, rd, er, lat);
            chk($sformatf("vec%0d_lat", i), 32'(lat), 32'd3);
            chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            chk($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
        end

        // Backpressure: response must stay put while resp_ready is low.
        txn(1'b0, 1'b0, 32'hFF, 32'h0, 1'b1, held, er, lat);
        chk("bp_lat", 32'(lat), 32'd3);
        chk("bp_rdata", held, 32'hCAFEF00D);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("bp_hold_rdata", bus_a.resp_rdata, held);
            chk("bp_hold_valid", 32'(bus_a.resp_valid), 32'h1);
            chk("bp_hold_req_ready", 32'(bus_a.req_ready), 32'h0);
        end
        bus_a.resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus_a.resp_ready = 1'b0;
        chk("bp_done_valid", 32'(bus_a.resp_valid), 32'h0);
        chk("bp_done_busy", 32'(busy_a), 32'h0);
        chk("bp_done_req_ready", 32'(bus_a.req_ready), 32'h1);

        // Reset during WAIT abandons the store to addr 7.
        @(negedge clk);
        drv(1'b0, 1'b1, 1'b1, 32'h07, 32'h12345678, 1'b0);
        @(posedge clk);
        @(negedge clk);
        drv(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        chk("mw_busy_pre", 32'(busy_a), 32'h1);
        rst = 1'b0;
        #1;
        chk("mw_busy", 32'(busy_a), 32'h0);
        chk("mw_req_ready", 32'(bus_a.req_ready), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        txn(1'b0, 1'b0, 32'h07, 32'h0, 1'b0, rd, er, lat);
        chk("mw_load7", rd, 32'h0);

        // Reset in RESP drops resp_valid without waiting for a clock.
        txn(1'b0, 1'b0, 32'h00, 32'h0, 1'b1, rd, er, lat);
        chk("mr_valid_pre", 32'(bus_a.resp_valid), 32'h1);
        #2;
        rst = 1'b0;
        #1;
        chk("mr_valid", 32'(bus_a.resp_valid), 32'h0);
        chk("mr_rdata", bus_a.resp_rdata, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // Zero-wait instance: fill, then back-to-back loads with req_valid held.
        for (int i = 0; i < 3; i++) begin
            txn(1'b1, 1'b1, 32'(i), exp_b[i], 1'b0, rd, er, lat);
            chk("b_store_lat", 32'(lat), 32'd1);
        end
        @(negedge clk);
        drv(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1);
        n_acc = 0; n_rsp = 0; pend = 1'b0;
        for (int c = 0; c < 30 && n_rsp < 3; c++) begin
            if (c != 0) @(negedge clk);
            if (pend) begin
                pend = 1'b0;
                bus_b.req_addr = 32'(n_acc);
                if (n_acc == 3) bus_b.req_valid = 1'b0;
            end
            if (bus_b.resp_valid) begin
                chk("b2b_rdata", bus_b.resp_rdata, exp_b[n_rsp]);
                rsp_cyc[n_rsp] = c;
                n_rsp++;
            end
            if (bus_b.req_valid && bus_b.req_ready && n_acc < 3) begin
                acc_cyc[n_acc] = c;
                n_acc++;
                pend = 1'b1;
            end
        end
        chk("b2b_n_rsp", 32'(n_rsp), 32'd3);
        if (n_rsp == 3) begin
            for (int i = 0; i < 3; i++)
                chk("b2b_resp_edges", 32'(rsp_cyc[i] - acc_cyc[i] - 1), 32'd1);
            chk("b2b_spacing01", 32'(acc_cyc[1] - acc_cyc[0]), 32'd3);
            chk("b2b_spacing12", 32'(acc_cyc[2] - acc_cyc[1]), 32'd3);
        end
        @(posedge clk);
        @(negedge clk);
        drv(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        chk("b2b_idle", 32'(busy_b), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_wait_responder.md
Name: mem_wait_responder

Overview:
Word-addressed data memory responder that serves the CPU's load/store requests over a valid/ready request channel and a valid/ready response channel. It inserts a programmable number of wait states before each access. This allows the multicycle datapath to be exercised against a non-zero-latency memory. It sits between the CPU's memory-access stage and the storage array, replacing the zero-latency combinational data memory.

Parameters:
ADDR_WIDTH, 8, word-address bits used; depth = 2**ADDR_WIDTH words
DATA_WIDTH, 32, word width
WAIT_CYCLES, 2, wait states inserted per access; legal range 0..15

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset; asynchronous, active-low
req_valid  input  1  request present
req_ready  output  1  responder can accept a request
req_write  input  1  1 = store, 0 = load
req_addr  input  32  word address
req_wdata  input  DATA_WIDTH  store data
resp_valid  output  1  response present
resp_ready  input  1  CPU accepts response
resp_rdata  output  DATA_WIDTH  load data; 0 for stores
resp_err  output  1  address error; constant 0 unless MEM_RESP_ERR_EN is defined
busy  output  1  high in WAIT or RESP

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; req_ready=0 while rst low; resp_valid=0, resp_rdata=0, resp_err=0, busy=0; wait counter=0.
  - Memory array contents are not cleared and are retained across reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1 (combinational from state), busy=0.
  - On an edge with req_valid && req_ready: capture req_write, req_addr, req_wdata into internal registers; load counter=WAIT_CYCLES; go to WAIT.
  - Request inputs are don't-care after capture.
- WAIT:
  - req_ready=0, busy=1.
  - Each edge with counter!=0: counter decrements by 1.
  - Edge with counter==0: perform the access and go to RESP.
    - Store: mem[addr[ADDR_WIDTH-1:0]] <= wdata; resp_rdata <= 0.
    - Load: resp_rdata <= mem[addr[ADDR_WIDTH-1:0]].
- RESP:
  - resp_valid=1, busy=1, req_ready=0.
  - resp_rdata and resp_err are held stable until the edge with resp_ready=1; on that edge go to IDLE and clear resp_valid.
- Latency: resp_valid rises exactly WAIT_CYCLES+1 edges after the accepting edge. With WAIT_CYCLES=0, that is 1 edge.
- Throughput:
  - At most one outstanding request.
  - No accept in the same cycle as a response handshake; the earliest next accept is the edge after returning to IDLE.
- Address wrap: upper bits req_addr[31:ADDR_WIDTH] are ignored, so addresses alias modulo depth. This applies when MEM_RESP_ERR_EN is undefined.
- Reset mid-operation: the request is abandoned and a store not yet reached its access edge is not performed. A response pending in RESP is discarded; resp_valid drops asynchronously.
- resp_ready held high in IDLE/WAIT has no effect.
- Load from a never-written location returns X in simulation. The bench initialises memory first.

Optional Feature:
MEM_RESP_ERR_EN
- Defined:
  - Any captured address with a nonzero bit in [31:ADDR_WIDTH] is out of range.
  - For such a request, the access edge performs no store and sets resp_rdata=0 and resp_err=1.
  - resp_err is held with resp_valid and cleared on the response handshake.
  - Wait timing is unchanged.
- Undefined: resp_err is tied to 0 and addresses wrap modulo depth.

Test Plan:
- Reset then idle: rst low → resp_valid=0, busy=0, resp_rdata=0; after rst high, req_ready=1.
- Store/load round trip, WAIT_CYCLES=2:
  - Store addr 5, data 0xDEADBEEF → resp_valid rises 3 edges after accept, resp_rdata=0.
  - Load addr 5 → resp_rdata=0xDEADBEEF after 3 edges.
- Response backpressure: hold resp_ready=0 for 4 cycles after resp_valid → resp_rdata stable and req_ready=0 throughout; IDLE entered on the edge resp_ready=1.
- WAIT_CYCLES=0 back-to-back: loads of addrs 0,1,2 with req_valid held high and resp_ready=1 → each response 1 edge after accept; accepts spaced 3 cycles apart.
- Reset mid-WAIT: store addr 7 = 0x12345678 over a prior 0x0; assert rst during WAIT → after release, load addr 7 returns 0x0.
- MEM_RESP_ERR_EN, ADDR_WIDTH=8:
  - Store addr 0x100 = 0xAAAA5555 → resp_err=1, resp_rdata=0.
  - Load addr 0x000 returns its old value, confirming no aliasing write.
